// File: rtl/cbus_arb_pkg.sv
// Shared types for the cbus arbiter slice.
//   arb_state_t  - arbiter FSM encoding
//   cbus_req_t   - master-side request (valid qualifies the rest)
//   cbus_resp_t  - memory-side response (last closes a transaction)
// The cbus structs normally come from the common header; they are carried
// here so the slice elaborates on its own.
package cbus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [3:0]  strb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] rdata;
  } cbus_resp_t;

endpackage

// File: rtl/cbus_rr_arbiter_rr_select.sv
// rr_select: combinational requester selection.
//   valid     in  N     requesting inputs
//   urgent    in  N     inputs whose wait has hit the age limit
//   ptr       in  IW    round-robin start index
//   rr_mode   in  1     1: rotate from ptr, 0: lowest index wins
//   sel       out IW    chosen input (0 when nothing is valid)
//   any_valid out 1     OR of valid
module rr_select #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [N-1:0]  urgent,
  input  logic [IW-1:0] ptr,
  input  logic          rr_mode,
  output logic [IW-1:0] sel,
  output logic          any_valid
);

  logic found;
  int   idx;

  always_comb begin
    sel       = '0;
    found     = 1'b0;
    idx       = 0;
    any_valid = |valid;

    // urgent inputs override both selection modes, lowest index first
    for (int i = 0; i < N; i++) begin
      if (!found && valid[i] && urgent[i]) begin
        sel   = IW'(i);
        found = 1'b1;
      end
    end

    if (!found && rr_mode) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && valid[idx]) begin
          sel   = IW'(idx);
          found = 1'b1;
        end
      end
    end

    if (!found) begin
      for (int i = 0; i < N; i++) begin
        if (!found && valid[i]) begin
          sel   = IW'(i);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// cbus_rr_arbiter: N-to-1 cbus arbiter towards the single memory-side port.
// The request is forwarded in the arbitration cycle itself and ownership is
// held until oresp.last.
//   clk          in   clock
//   resetn       in   asynchronous active-low reset
//   ireqs        in   master requests
//   iresps       out  responses, only the owner's entry is non-zero
//   oreq         out  request forwarded to the memory side
//   oresp        in   memory-side response
//   grant_valid  out  a master owns or is being granted the port
//   grant_idx    out  owning master, 0 when grant_valid=0
//
// state | meaning
// IDLE  | no owner; arbitrate and grant combinationally if any input is valid
// BUSY  | owner fixed until oresp.last
module cbus_rr_arbiter
  import cbus_arb_pkg::*;
#(
  parameter  int NUM_INPUTS  = 2,
  parameter  int ROUND_ROBIN = 1,
  parameter  int AGE_LIMIT   = 0,
  localparam int IDX_W       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  cbus_req_t        ireqs  [NUM_INPUTS],
  output cbus_resp_t       iresps [NUM_INPUTS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  arb_state_t            state_q, state_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      sel;
  logic                  any_valid;
  logic [NUM_INPUTS-1:0] valid_vec;
  logic [NUM_INPUTS-1:0] urgent;

  always_comb begin
    valid_vec = '0;
    for (int i = 0; i < NUM_INPUTS; i++) valid_vec[i] = ireqs[i].valid;
  end

  rr_select #(.N(NUM_INPUTS)) u_rr_select (
    .valid     (valid_vec),
    .urgent    (urgent),
    .ptr       (rr_ptr_q),
    .rr_mode   (ROUND_ROBIN != 0),
    .sel       (sel),
    .any_valid (any_valid)
  );

  // Outputs are forced to zero while reset is held, so an asserted resetn
  // silences the port in the same cycle even if requests are still valid.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    grant_valid = 1'b0;
    grant_idx   = '0;
    oreq        = '0;
    for (int i = 0; i < NUM_INPUTS; i++) iresps[i] = '0;

    if (resetn) begin
      unique case (state_q)
        IDLE: begin
          if (any_valid) begin
            grant_valid = 1'b1;
            grant_idx   = sel;
            owner_d     = sel;
            if (!oresp.last) state_d = BUSY;
          end
        end
        BUSY: begin
          grant_valid = 1'b1;
          grant_idx   = owner_q;
          if (oresp.last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (grant_valid) begin
        oreq              = ireqs[grant_idx];
        iresps[grant_idx] = oresp;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rr_ptr_q <= '0;
    end else if ((ROUND_ROBIN != 0) && grant_valid && oresp.last) begin
      rr_ptr_q <= (grant_idx == IDX_W'(NUM_INPUTS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  if (AGE_LIMIT > 0) begin : g_age
    localparam int            AW      = $clog2(AGE_LIMIT + 1);
    localparam logic [AW-1:0] AGE_MAX = AW'(AGE_LIMIT);

    logic [AW-1:0] age_q [NUM_INPUTS];

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        for (int i = 0; i < NUM_INPUTS; i++) age_q[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_INPUTS; i++) begin
          if (!ireqs[i].valid || (grant_valid && grant_idx == IDX_W'(i)))
            age_q[i] <= '0;
          else if (age_q[i] != AGE_MAX)
            age_q[i] <= age_q[i] + 1'b1;
        end
      end
    end

    always_comb begin
      urgent = '0;
      for (int i = 0; i < NUM_INPUTS; i++) urgent[i] = (age_q[i] == AGE_MAX);
    end
  end else begin : g_no_age
    assign urgent = '0;
  end

endmodule
